// File: rtl/sprite_draw_sequencer_pkg.sv
// sprite_seq_pkg: shared state encoding, pixel field widths and colour constants
package sprite_seq_pkg;
  typedef enum logic [2:0] {IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, FRAME_WAIT} state_t;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
  localparam logic [C_W-1:0] BLACK = 3'b000;
endpackage

// File: rtl/sprite_draw_sequencer_frame_timer.sv
// frame_timer: frame-length down-counter; expired stays high once it reaches zero
module frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(FRAME_CYCLES);
  logic [W-1:0] cnt;
  // load so that expiry lands exactly FRAME_CYCLES cycles after the load edge
  always_ff @(posedge clk) begin
    if (!reset) cnt <= '0;
    else if (load) cnt <= W'(FRAME_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per-frame erase/draw walk over sprite blocks with pixel forwarding to VGA
module sprite_draw_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int N_SPRITES      = 4,
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SPRITES-1:0]     sprite_en,
  output logic [N_SPRITES-1:0]     draw_req,
  output logic [N_SPRITES-1:0]     erase_req,
  input  logic [N_SPRITES-1:0]     sprite_done,
  input  logic [N_SPRITES-1:0]     sprite_valid,
  input  logic [X_W*N_SPRITES-1:0] sprite_x,
  input  logic [Y_W*N_SPRITES-1:0] sprite_y,
  input  logic [C_W*N_SPRITES-1:0] sprite_colour,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_colour,
  output logic                     vga_plot,
  output logic                     frame_tick,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     overrun_err
);
  localparam int IW  = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  state_t               state;
  logic [IW-1:0]        idx;
  logic [N_SPRITES-1:0] en_q, onehot;
  logic [TOW-1:0]       tcnt;
  logic first_frame, expired, last, req_st, wait_st, erase_ph, tout, step, draw_end, start;
  frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(start),
    .expired(expired)
  );
  assign last     = idx == IW'(N_SPRITES - 1);
  assign req_st   = state == ERASE_REQ || state == DRAW_REQ;
  assign wait_st  = state == ERASE_WAIT || state == DRAW_WAIT;
  assign erase_ph = state == ERASE_REQ || state == ERASE_WAIT;
  assign tout     = tcnt == TOW'(TIMEOUT_CYCLES - 1);
  assign onehot   = N_SPRITES'(1) << idx;
  // step: current sprite is finished, either skipped (disabled) or done/timed out
  assign step     = req_st ? !en_q[idx] : wait_st && (sprite_done[idx] || tout);
  assign draw_end = !erase_ph && step && last;
  // an overrunning pass chains straight into the next frame start
  assign start    = state == IDLE || (expired && (state == FRAME_WAIT || draw_end));
  // sequencer FSM with registered requests, status flags and pixel mux
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      en_q        <= '0;
      first_frame <= 1'b1;
      draw_req    <= '0;
      erase_req   <= '0;
      tcnt        <= '0;
      frame_tick  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= BLACK;
      vga_plot    <= 1'b0;
    end else begin
      frame_tick <= start;
      vga_plot   <= wait_st && sprite_valid[idx];
      if (wait_st) begin
        vga_x      <= sprite_x[X_W*idx +: X_W];
        vga_y      <= sprite_y[Y_W*idx +: Y_W];
        vga_colour <= sprite_colour[C_W*idx +: C_W];
      end
      tcnt <= wait_st ? tcnt + 1'b1 : '0;
      if (wait_st && tout && !sprite_done[idx]) timeout_err <= 1'b1;
      if (draw_end) first_frame <= 1'b0;
      if (draw_end && expired) overrun_err <= 1'b1;
      if (start) begin
        en_q      <= sprite_en;
        idx       <= '0;
        busy      <= 1'b1;
        draw_req  <= '0;
        erase_req <= '0;
        state     <= first_frame && !draw_end ? DRAW_REQ : ERASE_REQ;
      end else if (step) begin
        draw_req  <= '0;
        erase_req <= '0;
        idx       <= last ? '0 : idx + 1'b1;
        state     <= !last ? (erase_ph ? ERASE_REQ : DRAW_REQ) : (erase_ph ? DRAW_REQ : FRAME_WAIT);
        if (draw_end) busy <= 1'b0;
      end else if (req_st) begin
        erase_req <= erase_ph ? onehot : '0;
        draw_req  <= erase_ph ? '0 : onehot;
        state     <= erase_ph ? ERASE_WAIT : DRAW_WAIT;
      end
    end
  end
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb_sprite_draw_sequencer: directed scenario bench for the sprite draw/erase sequencer
module tb_sprite_draw_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sprite_en, draw_req, erase_req, sprite_done, sprite_valid;
  logic [17:0] sprite_x;
  logic [15:0] sprite_y;
  logic [5:0]  sprite_colour;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, frame_tick, busy, timeout_err, overrun_err;
  int passed = 0, total = 0, cyc = 0, t0 = 0;
  int lat[2];
  int scnt[2];
  logic [31:0] seq;
  int nreq, run;
  int lens[$];
  logic [3:0] prev_c = '0, cur;

  sprite_draw_sequencer #(.N_SPRITES(2), .FRAME_CYCLES(240), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .sprite_en(sprite_en), .draw_req(draw_req), .erase_req(erase_req),
    .sprite_done(sprite_done), .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_colour(sprite_colour), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .frame_tick(frame_tick), .busy(busy), .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  // sprite blocks: done pulses on the lat-th cycle a request is seen; lat 0 never answers
  initial begin
    sprite_done = '0;
    scnt[0] = 0;
    scnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (draw_req[i] || erase_req[i]) begin
          scnt[i]++;
          sprite_done[i] = lat[i] != 0 && scnt[i] == lat[i];
        end else begin
          scnt[i] = 0;
          sprite_done[i] = 1'b0;
        end
      end
    end
  end

  // request log: nibble {erase_req,draw_req} per request, plus its high time in cycles
  initial forever begin
    @(negedge clk);
    cur = {erase_req, draw_req};
    if (cur != prev_c) begin
      if (prev_c != 0) lens.push_back(run);
      if (cur != 0) begin
        seq = {seq[27:0], cur};
        nreq++;
        run = 1;
      end
    end else if (cur != 0) run++;
    prev_c = cur;
  end

  task automatic clear_log;
    seq = '0;
    nreq = 0;
    lens.delete();
  endtask

  function automatic logic cond(input int k);
    case (k)
      0: return frame_tick;
      1: return !busy;
      2: return draw_req == 2'b01;
      3: return erase_req == 2'b01;
      4: return draw_req != 2'b00;
      5: return draw_req == 2'b10;
      6: return draw_req == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!cond(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cond(k)) $display("FAIL wait_%s: condition not seen within %0d cycles", name, budget);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    sprite_en = 2'b11;
    sprite_valid = '0;
    sprite_x = '0;
    sprite_y = '0;
    sprite_colour = '0;
    lat[0] = 40;
    lat[1] = 40;
    clear_log();
    repeat (3) @(negedge clk);
    total++;
    if ({draw_req, erase_req, frame_tick, busy, timeout_err, overrun_err, vga_plot} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 0", {draw_req, erase_req, frame_tick, busy, timeout_err, overrun_err, vga_plot});
    else passed++;
    total++;
    if ({vga_x, vga_y, vga_colour} !== 20'b0) $display("FAIL reset_pixel: got %h want 0", {vga_x, vga_y, vga_colour});
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (frame_tick !== 1'b1 || busy !== 1'b1) $display("FAIL first_tick: tick=%b busy=%b want 1 1", frame_tick, busy);
    else passed++;
    t0 = cyc;
  endtask

  task automatic test_first_frame;
    clear_log();
    wait_for(1, 300, "busy1");
    @(negedge clk);
    total++;
    if (seq !== 32'h12 || nreq !== 2) $display("FAIL first_frame_seq: got %h/%0d want 12/2", seq, nreq);
    else passed++;
    total++;
    if (lens.size() != 2 || lens[0] != 40 || lens[1] != 40) $display("FAIL first_frame_len: got %p want 40 40", lens);
    else passed++;
  endtask

  task automatic test_second_frame;
    wait_for(0, 300, "tick2");
    total++;
    if (cyc - t0 !== 240) $display("FAIL frame_period: got %0d want 240", cyc - t0);
    else passed++;
    clear_log();
    wait_for(1, 300, "busy2");
    @(negedge clk);
    total++;
    if (seq !== 32'h4812 || nreq !== 4) $display("FAIL second_frame_seq: got %h/%0d want 4812/4", seq, nreq);
    else passed++;
    total++;
    if (lens.size() != 4 || lens[0] != 40 || lens[1] != 40 || lens[2] != 40 || lens[3] != 40)
      $display("FAIL second_frame_len: got %p want 40 x4", lens);
    else passed++;
    total++;
    if (timeout_err !== 1'b0 || overrun_err !== 1'b0) $display("FAIL second_frame_err: got %b%b want 00", timeout_err, overrun_err);
    else passed++;
  endtask

  task automatic test_pixel_mux;
    wait_for(0, 300, "tick3");
    wait_for(2, 300, "draw0");
    sprite_x = {9'd300, 9'd160};
    sprite_y = {8'd200, 8'd5};
    sprite_colour = {3'b010, 3'b101};
    sprite_valid = 2'b01;
    @(negedge clk);
    total++;
    if (vga_plot !== 1'b1 || vga_x !== 9'd160 || vga_y !== 8'd5 || vga_colour !== 3'b101)
      $display("FAIL pixel_fwd: got plot=%b x=%0d y=%0d c=%b want 1 160 5 101", vga_plot, vga_x, vga_y, vga_colour);
    else passed++;
    sprite_valid = 2'b10;
    @(negedge clk);
    total++;
    if (vga_plot !== 1'b0 || vga_x !== 9'd160) $display("FAIL pixel_other: got plot=%b x=%0d want 0 160", vga_plot, vga_x);
    else passed++;
    sprite_valid = 2'b00;
    wait_for(1, 300, "busy3");
    sprite_valid = 2'b11;
    @(negedge clk);
    total++;
    if (vga_plot !== 1'b0 || vga_x !== 9'd300) $display("FAIL pixel_idle: got plot=%b x=%0d want 0 300", vga_plot, vga_x);
    else passed++;
    sprite_valid = 2'b00;
    lat[1] = 64;
  endtask

  task automatic test_done_wins;
    wait_for(0, 300, "tick4");
    clear_log();
    wait_for(1, 300, "busy4");
    @(negedge clk);
    total++;
    if (seq !== 32'h4812 || lens.size() != 4 || lens[1] != 64 || lens[3] != 64 || timeout_err !== 1'b0)
      $display("FAIL done_wins: got seq=%h lens=%p terr=%b want 4812 len1/3=64 terr=0", seq, lens, timeout_err);
    else passed++;
    lat[1] = 0;
  endtask

  task automatic test_timeout;
    wait_for(0, 300, "tick5");
    clear_log();
    wait_for(1, 300, "busy5");
    @(negedge clk);
    total++;
    if (seq !== 32'h4812 || nreq !== 4) $display("FAIL timeout_seq: got %h/%0d want 4812/4", seq, nreq);
    else passed++;
    total++;
    if (lens.size() != 4 || lens[1] != 64 || lens[3] != 64) $display("FAIL timeout_len: got %p want len1/3=64", lens);
    else passed++;
    total++;
    if (timeout_err !== 1'b1 || overrun_err !== 1'b0) $display("FAIL timeout_err: got %b%b want 10", timeout_err, overrun_err);
    else passed++;
    lat[1] = 40;
  endtask

  task automatic test_en_change;
    wait_for(0, 300, "tick6");
    clear_log();
    wait_for(3, 300, "erase0");
    sprite_en = 2'b01;
    wait_for(1, 300, "busy6");
    @(negedge clk);
    total++;
    if (seq !== 32'h4812 || nreq !== 4) $display("FAIL en_mid_pass: got %h/%0d want 4812/4", seq, nreq);
    else passed++;
    wait_for(0, 300, "tick7");
    clear_log();
    wait_for(1, 300, "busy7");
    @(negedge clk);
    total++;
    if (seq !== 32'h41 || nreq !== 2) $display("FAIL en_next_frame: got %h/%0d want 41/2", seq, nreq);
    else passed++;
    sprite_en = 2'b11;
    lat[0] = 60;
    lat[1] = 60;
  endtask

  task automatic test_overrun;
    wait_for(0, 300, "tick8");
    total++;
    if (overrun_err !== 1'b0) $display("FAIL overrun_pre: got %b want 0", overrun_err);
    else passed++;
    wait_for(5, 300, "draw1");
    wait_for(6, 100, "draw1_drop");
    total++;
    if (frame_tick !== 1'b1 || overrun_err !== 1'b1 || busy !== 1'b1)
      $display("FAIL overrun: got tick=%b oerr=%b busy=%b want 1 1 1", frame_tick, overrun_err, busy);
    else passed++;
  endtask

  task automatic test_reset_mid;
    sprite_valid = 2'b11;
    wait_for(4, 300, "draw9");
    @(negedge clk);
    total++;
    if (vga_plot !== 1'b1 || draw_req !== 2'b01) $display("FAIL pre_reset: got plot=%b dreq=%b want 1 01", vga_plot, draw_req);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (draw_req !== 2'b00 || erase_req !== 2'b00 || vga_plot !== 1'b0 || busy !== 1'b0 || overrun_err !== 1'b0)
      $display("FAIL reset_mid: got dreq=%b ereq=%b plot=%b busy=%b oerr=%b want all 0", draw_req, erase_req, vga_plot, busy, overrun_err);
    else passed++;
    reset = 1'b1;
    sprite_valid = 2'b00;
    lat[0] = 40;
    lat[1] = 40;
    wait_for(0, 10, "tick_post_reset");
    clear_log();
    wait_for(1, 300, "busy_post_reset");
    @(negedge clk);
    total++;
    if (seq !== 32'h12 || nreq !== 2) $display("FAIL post_reset_seq: got %h/%0d want 12/2", seq, nreq);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_pixel_mux();
    test_done_wins();
    test_timeout();
    test_en_change();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
